cactus_spawner: RTL

Downstream consumer of the 5-bit pseudo-random value from `rng`. It decides when and what kind of cactus to spawn, and holds a small pool of active cactus slots. On each scroll tick it moves every active cactus left, retires cacti that leave the screen, and hands their positions to the renderer and collision logic.

---
 rtl/dino_pkg.sv | 26 ++
 rtl/cactus_spawner_if.sv | 27 ++
 rtl/cactus_slot.sv | 64 ++++++
 rtl/cactus_spawner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants and enumerations for the dino game cactus logic.
package dino_pkg;

    localparam int X_W      = 10;
    localparam int SCREEN_W = 640;

    typedef enum logic [1:0] {
        SMALL  = 2'd0,
        TALL   = 2'd1,
        DOUBLE = 2'd2,
        WIDE   = 2'd3
    } cactus_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SPAWN = 2'd2
    } spawn_state_t;

    // Bits needed for the spawn gap counter so that the largest reload
    // value (MIN_GAP + 7*GAP_STEP) fits without overflow.
    function automatic int gap_width(input int min_gap, input int gap_step);
        return $clog2(min_gap + 7 * gap_step + 1);
    endfunction

endpackage

// File: rtl/cactus_spawner_if.sv
// Control inputs and cactus pool outputs of the cactus spawner.
// master: game controller side, slave: spawner side.
interface cactus_spawner_if
    import dino_pkg::*;
#(
    parameter int NUM_SLOTS = 3
);
    logic                     run;
    logic                     clear;
    logic                     scroll_tick;
    logic [4:0]               rnd;
    logic [NUM_SLOTS-1:0]     cactus_valid;
    logic [NUM_SLOTS*X_W-1:0] cactus_x;
    logic [NUM_SLOTS*2-1:0]   cactus_type;
    logic                     spawn_pulse;
    logic                     passed_pulse;

    modport master (
        output run, clear, scroll_tick, rnd,
        input  cactus_valid, cactus_x, cactus_type, spawn_pulse, passed_pulse
    );

    modport slave (
        input  run, clear, scroll_tick, rnd,
        output cactus_valid, cactus_x, cactus_type, spawn_pulse, passed_pulse
    );
endinterface

// File: rtl/cactus_slot.sv
// One cactus slot: holds valid/x/type, loads a fresh cactus at the right
// screen edge and scrolls it left by 'speed' on each step.
module cactus_slot
    import dino_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    input  logic [X_W-1:0] speed,
    input  logic           load,
    input  cactus_type_t   load_type,
    output logic           valid,
    output logic [X_W-1:0] x,
    output cactus_type_t   ctype,
    output logic           retire
);
    logic         valid_q, valid_d;
    logic [X_W-1:0] x_q, x_d;
    cactus_type_t type_q, type_d;

    // A live cactus that cannot take a full step leaves the screen this step.
    assign retire = step && valid_q && (x_q < speed);

    // Next slot contents: clear wins, load only ever targets an empty slot.
    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        type_d  = type_q;
        if (clear) begin
            valid_d = 1'b0;
            x_d     = '0;
            type_d  = SMALL;
        end else if (load) begin
            valid_d = 1'b1;
            x_d     = X_W'(SCREEN_W - 1);
            type_d  = load_type;
        end else if (step && valid_q) begin
            if (x_q >= speed) begin
                x_d = x_q - speed;
            end else begin
                valid_d = 1'b0;
                x_d     = '0;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            type_q  <= SMALL;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            type_q  <= type_d;
        end
    end

    assign valid = valid_q;
    assign x     = x_q;
    assign ctype = type_q;
endmodule

// File: rtl/cactus_spawner.sv
// Cactus spawner: spawn-timing FSM, gap counter, free-slot picker and
// pulse generation around a pool of cactus_slot instances.
// Optional build macro CACTUS_SPEEDUP_EN: scroll speed grows by one every
// 16 retired cacti, saturating at SPEED+3.
module cactus_spawner
    import dino_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
    parameter int SPEED     = 2,
    parameter int MIN_GAP   = 40,
    parameter int GAP_STEP  = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    cactus_spawner_if.slave   bus
);
    localparam int GAP_W = gap_width(MIN_GAP, GAP_STEP);

    logic                 tick;
    spawn_state_t         state_q, state_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 spawn_pulse_q, spawn_pulse_d;
    logic                 passed_pulse_q, passed_pulse_d;
    logic [X_W-1:0]       speed;
    logic [NUM_SLOTS-1:0] slot_valid, slot_retire, slot_load, free_onehot;
    logic                 free_any, do_spawn;
    logic [X_W-1:0]       slot_x    [NUM_SLOTS];
    cactus_type_t         slot_type [NUM_SLOTS];

    // clear takes precedence over any qualifying tick.
    assign tick = bus.run && bus.scroll_tick && !bus.clear;

    // Lowest-index slot that was empty before this tick; a slot retiring on
    // the same tick still reads valid here, so it is reused one tick later.
    always_comb begin
        free_onehot = '0;
        free_any    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_valid[i] && !free_any) begin
                free_onehot[i] = 1'b1;
                free_any       = 1'b1;
            end
        end
    end

    assign do_spawn  = tick && (state_q == SPAWN) && free_any;
    assign slot_load = {NUM_SLOTS{do_spawn}} & free_onehot;

    // Spawn FSM next state, gap counter and pulse requests.
    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        spawn_pulse_d  = do_spawn;
        passed_pulse_d = tick && (|slot_retire);
        if (bus.clear) begin
            state_d = IDLE;
            gap_d   = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    gap_d   = GAP_W'(MIN_GAP);
                end
                WAIT: begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) state_d = SPAWN;
                end
                SPAWN: begin
                    if (free_any) begin
                        state_d = WAIT;
                        gap_d   = GAP_W'(MIN_GAP) + GAP_W'(bus.rnd[4:2]) * GAP_W'(GAP_STEP);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, gap and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gap_q          <= '0;
            spawn_pulse_q  <= 1'b0;
            passed_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            spawn_pulse_q  <= spawn_pulse_d;
            passed_pulse_q <= passed_pulse_d;
        end
    end

`ifdef CACTUS_SPEEDUP_EN
    logic [3:0]     ret_cnt_q, ret_cnt_d;
    logic [X_W-1:0] speed_q, speed_d;
    logic [4:0]     ret_sum;

    // Count retirements; each wrap of the 4-bit counter bumps the speed.
    always_comb begin
        ret_sum = {1'b0, ret_cnt_q};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ret_sum = ret_sum + 5'(slot_retire[i]);
        end
        ret_cnt_d = ret_cnt_q;
        speed_d   = speed_q;
        if (bus.clear) begin
            ret_cnt_d = '0;
            speed_d   = X_W'(SPEED);
        end else if (tick) begin
            ret_cnt_d = ret_sum[3:0];
            if (ret_sum[4] && (speed_q < X_W'(SPEED + 3))) speed_d = speed_q + X_W'(1);
        end
    end

    // Speed-up registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt_q <= '0;
            speed_q   <= X_W'(SPEED);
        end else begin
            ret_cnt_q <= ret_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign speed = speed_q;
`else
    assign speed = X_W'(SPEED);
`endif

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        cactus_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (bus.clear),
            .step      (tick),
            .speed     (speed),
            .load      (slot_load[gi]),
            .load_type (cactus_type_t'(bus.rnd[1:0])),
            .valid     (slot_valid[gi]),
            .x         (slot_x[gi]),
            .ctype     (slot_type[gi]),
            .retire    (slot_retire[gi])
        );
        assign bus.cactus_x[gi*X_W +: X_W] = slot_x[gi];
        assign bus.cactus_type[gi*2 +: 2]  = slot_type[gi];
    end

    assign bus.cactus_valid = slot_valid;
    assign bus.spawn_pulse  = spawn_pulse_q;
    assign bus.passed_pulse = passed_pulse_q;
endmodule
